ula_8bits: RTL and testbench

//  8-bit ALU: arithmetic (add/sub/mul/div/mod), bitwise logic and unsigned

---
 rtl/ula_8bits.sv | 118 +++++++++++
 tb/tb_ula_8bits.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/ula_8bits.sv
// 8-bit ALU execute stage: arithmetic, bitwise logic and unsigned compare, all outputs registered.
// Optional Overflow output enabled by defining OVERFLOW_FLAG_EN.
module ula_8bits (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  input  logic [3:0]  Sel_Op,
`ifdef OVERFLOW_FLAG_EN
  output logic        Overflow,
`endif
  output logic [15:0] Resultado,
  output logic        Maior,
  output logic        Menor,
  output logic        Igual
);

  localparam logic [3:0] OpAdd  = 4'b0000;
  localparam logic [3:0] OpSub  = 4'b0001;
  localparam logic [3:0] OpMul  = 4'b0010;
  localparam logic [3:0] OpDiv  = 4'b0011;
  localparam logic [3:0] OpMod  = 4'b0100;
  localparam logic [3:0] OpAnd  = 4'b0110;
  localparam logic [3:0] OpOr   = 4'b0111;
  localparam logic [3:0] OpNand = 4'b1000;
  localparam logic [3:0] OpNor  = 4'b1001;
  localparam logic [3:0] OpXor  = 4'b1010;
  localparam logic [3:0] OpNot  = 4'b1011;

  logic [15:0] res_d, res_q;
  logic        maior_q, menor_q, igual_q;
  logic        ovf_d;
  logic [8:0]  sum;
  logic [8:0]  diff;
  logic [15:0] prod;
  logic        b_zero;

  assign sum    = {1'b0, A} + {1'b0, B};
  // Bit 8 of the 9-bit difference is the borrow (set iff A < B).
  assign diff   = {1'b0, A} - {1'b0, B};
  assign prod   = {8'h00, A} * {8'h00, B};
  assign b_zero = (B == 8'h00);

  always_comb begin
    res_d = 16'h0000;
    ovf_d = 1'b0;
    case (Sel_Op)
      OpAdd: begin
        res_d = {7'b0, sum};
        ovf_d = sum[8];
      end
      OpSub: begin
        res_d = {7'b0, diff};
        ovf_d = diff[8];
      end
      OpMul: begin
        res_d = prod;
        ovf_d = (prod[15:8] != 8'h00);
      end
      OpDiv: begin
        // Divide by zero saturates rather than trapping.
        res_d = b_zero ? 16'h00FF : {8'h00, A / B};
        ovf_d = b_zero;
      end
      OpMod: begin
        res_d = b_zero ? {8'h00, A} : {8'h00, A % B};
        ovf_d = b_zero;
      end
      OpAnd:  res_d = {8'h00, A & B};
      OpOr:   res_d = {8'h00, A | B};
      OpNand: res_d = {8'h00, ~(A & B)};
      OpNor:  res_d = {8'h00, ~(A | B)};
      OpXor:  res_d = {8'h00, A ^ B};
      OpNot:  res_d = {8'h00, ~A};
      default: begin
        res_d = 16'h0000;
        ovf_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q   <= 16'h0000;
      maior_q <= 1'b0;
      menor_q <= 1'b0;
      igual_q <= 1'b0;
    end else begin
      res_q   <= res_d;
      maior_q <= (A > B);
      menor_q <= (A < B);
      igual_q <= (A == B);
    end
  end

  assign Resultado = res_q;
  assign Maior     = maior_q;
  assign Menor     = menor_q;
  assign Igual     = igual_q;

`ifdef OVERFLOW_FLAG_EN
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign Overflow = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_d;
`endif

endmodule

// File: tb/tb_ula_8bits.sv
// Bench for ula_8bits: directed cases plus random operations against an arithmetic reference model.
module tb_ula_8bits;

  logic        clk;
  logic        rst;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [3:0]  Sel_Op;
  logic [15:0] Resultado;
  logic        Maior, Menor, Igual;
`ifdef OVERFLOW_FLAG_EN
  logic        Overflow;
`endif

  int errors = 0;
  int checks = 0;

  ula_8bits dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .B         (B),
    .Sel_Op    (Sel_Op),
`ifdef OVERFLOW_FLAG_EN
    .Overflow  (Overflow),
`endif
    .Resultado (Resultado),
    .Maior     (Maior),
    .Menor     (Menor),
    .Igual     (Igual)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_result(input int a, input int b, input int op);
    int r;
    case (op)
      0:  r = a + b;
      1:  r = (a - b) & 'h1FF;
      2:  r = a * b;
      3:  r = (b == 0) ? 255 : a / b;
      4:  r = (b == 0) ? a : a % b;
      6:  r = a & b;
      7:  r = a | b;
      8:  r = (~(a & b)) & 'hFF;
      9:  r = (~(a | b)) & 'hFF;
      10: r = a ^ b;
      11: r = (~a) & 'hFF;
      default: r = 0;
    endcase
    return r[15:0];
  endfunction

  function automatic logic ref_ovf(input int a, input int b, input int op);
    case (op)
      0:       return (a + b) > 255;
      1:       return a < b;
      2:       return (a * b) > 255;
      3, 4:    return b == 0;
      default: return 1'b0;
    endcase
  endfunction

  // Apply one operation, clock it in, then compare registered outputs.
  task automatic do_op(input string tag, input int a, input int b, input int op, input bit r);
    logic [2:0] flags_exp;
    A = a[7:0];
    B = b[7:0];
    Sel_Op = op[3:0];
    rst = r;
    @(posedge clk);
    #1;
    flags_exp = r ? 3'b000 : {a > b, a < b, a == b};
    check({tag, ".res"}, Resultado, r ? 16'h0000 : ref_result(a, b, op));
    check({tag, ".flags"}, {13'b0, Maior, Menor, Igual}, {13'b0, flags_exp});
`ifdef OVERFLOW_FLAG_EN
    check({tag, ".ovf"}, {15'b0, Overflow}, {15'b0, (r ? 1'b0 : ref_ovf(a, b, op))});
`endif
  endtask

  initial begin
    rst = 1'b1;
    A = 8'd0;
    B = 8'd0;
    Sel_Op = 4'd0;

    do_op("reset", 50, 30, 0, 1'b1);
    do_op("add", 50, 30, 0, 1'b0);
    check("add.lit", Resultado, 16'd80);
    do_op("add_carry", 200, 100, 0, 1'b0);
    check("add_carry.lit", Resultado, 16'h012C);
    do_op("sub", 100, 30, 1, 1'b0);
    do_op("sub_borrow", 15, 20, 1, 1'b0);
    check("sub_borrow.lit", Resultado, 16'h01FB);
    do_op("mul_eq", 20, 20, 2, 1'b0);
    check("mul_eq.lit", Resultado, 16'd400);
    do_op("mul", 3, 90, 2, 1'b0);
    do_op("mul_max", 255, 255, 2, 1'b0);
    do_op("div", 100, 5, 3, 1'b0);
    do_op("mod", 23, 5, 4, 1'b0);
    do_op("div0", 23, 0, 3, 1'b0);
    check("div0.lit", Resultado, 16'h00FF);
    do_op("mod0", 23, 0, 4, 1'b0);
    do_op("and", 'hF0, 'hAA, 6, 1'b0);
    check("and.lit", Resultado, 16'h00A0);
    do_op("or", 'hF0, 'hAA, 7, 1'b0);
    do_op("nand", 'hF0, 'hAA, 8, 1'b0);
    do_op("nor", 'hF0, 'hAA, 9, 1'b0);
    do_op("xor", 'hF0, 'hAA, 10, 1'b0);
    do_op("not", 'hF0, 'hAA, 11, 1'b0);
    check("not.lit", Resultado, 16'h000F);
    do_op("rsv5", 'hF0, 'hAA, 5, 1'b0);
    do_op("rsv15", 'hF0, 'hAA, 15, 1'b0);
    // Reset mid-stream overrides the operation, then normal operation resumes.
    do_op("mid_rst", 200, 100, 2, 1'b1);
    do_op("post_rst", 7, 9, 2, 1'b0);

    for (int i = 0; i < 400; i++) begin
      int a, b, op;
      bit r;
      a  = $urandom_range(0, 255);
      b  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
      if ($urandom_range(0, 9) == 0) b = a;
      op = $urandom_range(0, 15);
      r  = ($urandom_range(0, 31) == 0);
      do_op("rand", a, b, op, r);
    end

    // Outputs must hold while inputs change between edges.
    A = 8'd1;
    B = 8'd2;
    Sel_Op = 4'd0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    A = 8'd250;
    B = 8'd3;
    Sel_Op = 4'd2;
    #3;
    check("hold", Resultado, 16'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
